// File: rtl/pwm_ramp_controller_pkg.sv
// Shared types and helpers for the PWM ramp controller slice.
// The state encoding is the one every PWM consumer reads off the state output.
package pwm_ramp_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2,
    ST_STOP = 2'd3
  } ctrl_state_e;

  localparam int DEFAULT_RESOLUTION       = 8;
  localparam int DEFAULT_STEP             = 4;
  localparam int DEFAULT_STEP_PERIODS     = 1;
  localparam int DEFAULT_WATCHDOG_PERIODS = 64;

  // Bits needed to hold any value in 0..maxValue, never less than one.
  function automatic int counterWidth(input int maxValue);
    if (maxValue < 1) begin
      return 1;
    end
    return $clog2(maxValue + 1);
  endfunction

endpackage

// File: rtl/pwm_ramp_controller_if.sv
// Command handshake between the vehicle control logic (master) and the ramp controller (slave).
interface pwm_ramp_controller_if #(
  parameter int RESOLUTION = 8
) ();

  logic                  cmd_valid;
  logic [RESOLUTION-1:0] cmd_duty;
  logic                  cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_duty,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_duty,
    output cmd_ready
  );

endinterface

// File: rtl/pwm_ramp_controller_watchdog.sv
// Counts PWM period boundaries since the last kick and pulses expired_o on the boundary
// that brings the count to PERIODS; PERIODS=0 disables expiry entirely.
module pwm_period_watchdog
  import pwm_ramp_controller_pkg::*;
#(
  parameter int PERIODS = DEFAULT_WATCHDOG_PERIODS
) (
  input  logic clk,
  input  logic rst,
  input  logic kick_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam bit ENABLED = (PERIODS > 0);
  localparam int LIMIT   = ENABLED ? PERIODS : 1;
  localparam int CW      = counterWidth(LIMIT);

  localparam logic [CW-1:0] COUNT_MAX  = CW'(LIMIT);
  localparam logic [CW-1:0] COUNT_LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q, count_d;

  // The count parks at the limit so expiry fires exactly once until the next kick.
  always_comb begin
    count_d = count_q;
    if (kick_i) begin
      count_d = '0;
    end else if (tick_i && (count_q != COUNT_MAX)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = ENABLED && tick_i && !kick_i && (count_q == COUNT_LAST);

endmodule

// File: rtl/pwm_ramp_controller.sv
// Sequences the duty command of one PWM: accepts targets, ramps toward them in bounded
// steps on PWM period boundaries, and handles emergency stop and command-silence watchdog.
module pwm_ramp_controller
  import pwm_ramp_controller_pkg::*;
#(
  parameter int RESOLUTION       = DEFAULT_RESOLUTION,
  parameter int STEP             = DEFAULT_STEP,
  parameter int STEP_PERIODS     = DEFAULT_STEP_PERIODS,
  parameter int WATCHDOG_PERIODS = DEFAULT_WATCHDOG_PERIODS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RESOLUTION-1:0] pwm_counter_i,
  pwm_ramp_controller_if.slave  cmd_if,
  input  logic                  estop_i,
  output logic [RESOLUTION-1:0] pulse_width_control_o,
  output logic [1:0]            state_o,
  output logic                  at_target_o,
  output logic                  watchdog_expired_o
);

  localparam int DW = counterWidth(STEP_PERIODS - 1);

  localparam logic [DW-1:0]     DIV_LAST = DW'(STEP_PERIODS - 1);
  localparam logic [RESOLUTION:0] STEP_W = (RESOLUTION + 1)'(STEP);

  ctrl_state_e           state_q, state_d;
  logic [RESOLUTION-1:0] pwc_q, pwc_d;
  logic [RESOLUTION-1:0] target_q, target_d;
  logic                  expired_q, expired_d;
  logic [DW-1:0]         div_q, div_d;

  logic                  boundary;
  logic                  accept;
  logic                  kick;
  logic                  stepNow;
  logic                  wdTick;
  logic                  wdExpired;

  logic [RESOLUTION:0]   pwcWide;
  logic [RESOLUTION:0]   targetWide;
  logic [RESOLUTION:0]   distance;
  logic [RESOLUTION:0]   stepWide;
  logic [RESOLUTION:0]   nextWide;
  logic [RESOLUTION-1:0] steppedPwc;

  assign boundary         = (pwm_counter_i == {RESOLUTION{1'b1}});
  assign cmd_if.cmd_ready = !rst && (state_q != ST_STOP);
  assign accept           = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign kick             = accept && !estop_i;
  assign stepNow          = boundary && (div_q == DIV_LAST);
  assign wdTick           = boundary && !estop_i &&
                            ((state_q == ST_RAMP) || (state_q == ST_HOLD));

  pwm_period_watchdog #(
    .PERIODS (WATCHDOG_PERIODS)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .kick_i    (kick),
    .tick_i    (wdTick),
    .expired_o (wdExpired)
  );

  // One guard bit keeps the step from wrapping past full scale or below zero.
  always_comb begin
    pwcWide    = {1'b0, pwc_q};
    targetWide = {1'b0, target_q};
    distance   = (targetWide >= pwcWide) ? (targetWide - pwcWide) : (pwcWide - targetWide);
    stepWide   = (distance > STEP_W) ? STEP_W : distance;
    nextWide   = (targetWide >= pwcWide) ? (pwcWide + stepWide) : (pwcWide - stepWide);
    steppedPwc = nextWide[RESOLUTION] ? {RESOLUTION{1'b1}} : nextWide[RESOLUTION-1:0];
  end

  always_comb begin
    div_d = div_q;
    if (boundary) begin
      div_d = (div_q == DIV_LAST) ? '0 : (div_q + DW'(1));
    end
  end

  // Next-state: estop overrides everything, then a fresh command, then watchdog expiry.
  always_comb begin
    state_d   = state_q;
    pwc_d     = pwc_q;
    target_d  = target_q;
    expired_d = expired_q;
    if (estop_i) begin
      state_d  = ST_STOP;
      pwc_d    = '0;
      target_d = '0;
    end else begin
      if (kick) begin
        target_d  = cmd_if.cmd_duty;
        expired_d = 1'b0;
      end else if (wdExpired) begin
        target_d  = '0;
        expired_d = 1'b1;
      end
      case (state_q)
        ST_STOP: begin
          if (boundary) begin
            state_d = ST_IDLE;
          end
        end
        ST_RAMP: begin
          if (stepNow) begin
            pwc_d = steppedPwc;
            if (steppedPwc == target_d) begin
              state_d = (target_d == '0) ? ST_IDLE : ST_HOLD;
            end
          end
        end
        ST_IDLE, ST_HOLD: begin
          if (target_q != pwc_q) begin
            state_d = ST_RAMP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pwc_q     <= '0;
      target_q  <= '0;
      expired_q <= 1'b0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      pwc_q     <= pwc_d;
      target_q  <= target_d;
      expired_q <= expired_d;
      div_q     <= div_d;
    end
  end

  assign pulse_width_control_o = pwc_q;
  assign state_o               = state_q;
  assign at_target_o           = (pwc_q == target_q);
  assign watchdog_expired_o    = expired_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Self-checking bench: the bench plays the PWM counter with random strides and compares
// every cycle against a behavioural model of the ramp controller, plus directed scenarios.
module tb_pwm_ramp_controller;

  localparam int RES  = 8;
  localparam int STEP = 4;
  localparam int SP   = 1;
  localparam int WD   = 8;
  localparam int TOP  = 255;

  logic           clk = 1'b0;
  logic           rst;
  logic [RES-1:0] pwmCounter;
  logic           estop;
  logic [RES-1:0] pulseWidth;
  logic [1:0]     state;
  logic           atTarget;
  logic           wdExpired;

  pwm_ramp_controller_if #(.RESOLUTION(RES)) cmdIf ();

  pwm_ramp_controller #(
    .RESOLUTION       (RES),
    .STEP             (STEP),
    .STEP_PERIODS     (SP),
    .WATCHDOG_PERIODS (WD)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .pwm_counter_i         (pwmCounter),
    .cmd_if                (cmdIf),
    .estop_i               (estop),
    .pulse_width_control_o (pulseWidth),
    .state_o               (state),
    .at_target_o           (atTarget),
    .watchdog_expired_o    (wdExpired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 0=IDLE 1=RAMP 2=HOLD 3=STOP
  int mPwc, mTgt, mState, mWd, mDiv;
  bit mExp;
  bit lastBoundary;

  function automatic void modelReset();
    mPwc = 0; mTgt = 0; mState = 0; mWd = 0; mDiv = 0; mExp = 1'b0;
  endfunction

  function automatic void modelClock(bit v, int duty, bit e, int cnt);
    bit bnd, acc, expire, stepNow, counting;
    int nP, nT, nS, nWd, nDiv, delta;
    bit nE;
    bnd      = (cnt == TOP);
    acc      = v && (mState != 3) && !e;
    stepNow  = bnd && (mDiv == SP - 1);
    counting = bnd && !e && (mState == 1 || mState == 2);
    nP = mPwc; nT = mTgt; nS = mState; nWd = mWd; nE = mExp; nDiv = mDiv;
    expire = 1'b0;
    if (bnd) nDiv = (mDiv + 1) % SP;
    if (acc) nWd = 0;
    else if (counting && mWd < WD) begin
      nWd = mWd + 1;
      expire = (nWd == WD);
    end
    if (e) begin
      nS = 3; nP = 0; nT = 0;
    end else begin
      if (acc) begin nT = duty; nE = 1'b0; end
      else if (expire) begin nT = 0; nE = 1'b1; end
      if (mState == 3) begin
        if (bnd) nS = 0;
      end else if (mState == 1) begin
        if (stepNow) begin
          delta = mTgt - mPwc;
          if (delta > STEP) delta = STEP;
          if (delta < -STEP) delta = -STEP;
          nP = mPwc + delta;
          if (nP == nT) nS = (nT == 0) ? 0 : 2;
        end
      end else if (mTgt != mPwc) begin
        nS = 1;
      end
    end
    mPwc = nP; mTgt = nT; mState = nS; mWd = nWd; mExp = nE; mDiv = nDiv;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    assert (actual === expected)
    else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string tag);
    total++;
    bad++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic checkOutput();
    checkValue("pwc",      32'(pulseWidth),      32'(mPwc));
    checkValue("state",    32'(state),           32'(mState));
    checkValue("ready",    32'(cmdIf.cmd_ready), (rst || mState == 3) ? 32'd0 : 32'd1);
    checkValue("atTarget", 32'(atTarget),        (mPwc == mTgt) ? 32'd1 : 32'd0);
    checkValue("expired",  32'(wdExpired),       32'(mExp));
  endtask

  task automatic applyStimulus(input bit v, input int duty, input bit e);
    int cnt, nxt;
    bit r;
    cmdIf.cmd_valid = v;
    cmdIf.cmd_duty  = duty[RES-1:0];
    estop           = e;
    cnt = int'(pwmCounter);
    r   = rst;
    @(posedge clk);
    if (r) modelReset();
    else   modelClock(v, duty, e, cnt);
    lastBoundary = (cnt == TOP);
    #1;
    nxt = cnt + int'($urandom_range(24, 64));
    pwmCounter = (cnt == TOP) ? 8'd0 : ((nxt > TOP) ? 8'd255 : nxt[RES-1:0]);
    cmdIf.cmd_valid = 1'b0;
    checkOutput();
  endtask

  task automatic nextBoundary();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 0, 1'b0);
      if (lastBoundary) return;
    end
    timeoutFail("boundaryWait");
  endtask

  // Re-offers the command periodically so the watchdog stays quiet during long ramps.
  task automatic driveTo(input int duty, input int budget);
    for (int i = 0; i < budget; i++) begin
      applyStimulus(i % 24 == 0, duty, 1'b0);
      if (mPwc == duty && mTgt == duty && mState != 1) return;
    end
    timeoutFail("driveTo");
  endtask

  int steps[$];
  int prev;
  int expDuty;

  initial begin
    rst = 1'b1; estop = 1'b0; pwmCounter = 8'd0;
    cmdIf.cmd_valid = 1'b0; cmdIf.cmd_duty = '0;
    modelReset();
    #2;
    checkValue("resetPwc",      32'(pulseWidth),      32'd0);
    checkValue("resetState",    32'(state),           32'd0);
    checkValue("resetReady",    32'(cmdIf.cmd_ready), 32'd0);
    checkValue("resetAtTarget", 32'(atTarget),        32'd1);
    checkValue("resetExpired",  32'(wdExpired),       32'd0);
    applyStimulus(1'b1, 77, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    rst = 1'b0;

    // Ramp up to 20 in steps of 4
    applyStimulus(1'b1, 20, 1'b0);
    prev = 0;
    for (int i = 0; i < 150 && steps.size() < 5; i++) begin
      applyStimulus(1'b0, 0, 1'b0);
      if (int'(pulseWidth) != prev) begin
        steps.push_back(int'(pulseWidth));
        prev = int'(pulseWidth);
        if (steps.size() == 1) checkValue("t1RampState", 32'(state), 32'd1);
      end
    end
    checkValue("t1StepCount", 32'(steps.size()), 32'd5);
    for (int k = 0; k < steps.size() && k < 5; k++)
      checkValue("t1Step", 32'(steps[k]), 32'(4 * (k + 1)));
    checkValue("t1HoldState", 32'(state),    32'd2);
    checkValue("t1AtTarget",  32'(atTarget), 32'd1);

    // Partial step down to 18
    applyStimulus(1'b1, 18, 1'b0);
    for (int i = 0; i < 80 && pulseWidth == 8'd20; i++) applyStimulus(1'b0, 0, 1'b0);
    checkValue("t2Pwc",        32'(pulseWidth),   32'd18);
    checkValue("t2OnBoundary", 32'(lastBoundary), 32'd1);
    checkValue("t2State",      32'(state),        32'd2);

    // Saturation at full scale, command offered on a boundary cycle
    driveTo(248, 3000);
    for (int i = 0; i < 20 && pwmCounter != 8'd255; i++) applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b1, 255, 1'b0);
    checkValue("t3SameBoundary", 32'(pulseWidth), 32'd248);
    nextBoundary();
    checkValue("t3First",  32'(pulseWidth), 32'd252);
    nextBoundary();
    checkValue("t3Second", 32'(pulseWidth), 32'd255);
    nextBoundary();
    checkValue("t3NoWrap", 32'(pulseWidth), 32'd255);

    // Emergency stop mid-ramp at 12
    driveTo(0, 4000);
    applyStimulus(1'b1, 40, 1'b0);
    for (int i = 0; i < 200 && mPwc != 12; i++) applyStimulus(1'b0, 0, 1'b0);
    checkValue("t4PreStop", 32'(pulseWidth), 32'd12);
    applyStimulus(1'b0, 0, 1'b1);
    checkValue("t4Pwc",   32'(pulseWidth),      32'd0);
    checkValue("t4State", 32'(state),           32'd3);
    checkValue("t4Ready", 32'(cmdIf.cmd_ready), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 100, 1'b1);
    applyStimulus(1'b1, 100, 1'b0);
    if (!lastBoundary) nextBoundary();
    checkValue("t4Idle",      32'(state),      32'd0);
    checkValue("t4Ignored",   32'(atTarget),   32'd1);
    checkValue("t4StillZero", 32'(pulseWidth), 32'd0);

    // Watchdog expiry from HOLD 20 and ramp down
    driveTo(20, 1000);
    applyStimulus(1'b1, 20, 1'b0);
    for (int i = 0; i < 20 && !wdExpired; i++) nextBoundary();
    checkValue("t5Expired", 32'(wdExpired), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      nextBoundary();
      checkValue("t5Down", 32'(pulseWidth), 32'(20 - 4 * k));
    end
    checkValue("t5Idle", 32'(state), 32'd0);
    applyStimulus(1'b1, 8, 1'b0);
    checkValue("t5Cleared", 32'(wdExpired), 32'd0);

    // Asynchronous reset between clock edges during a ramp
    applyStimulus(1'b1, 200, 1'b0);
    for (int i = 0; i < 3; i++) nextBoundary();
    #3;
    rst = 1'b1;
    #1;
    checkValue("t6Pwc",      32'(pulseWidth),      32'd0);
    checkValue("t6State",    32'(state),           32'd0);
    checkValue("t6Ready",    32'(cmdIf.cmd_ready), 32'd0);
    checkValue("t6AtTarget", 32'(atTarget),        32'd1);
    checkValue("t6Expired",  32'(wdExpired),       32'd0);
    modelReset();
    applyStimulus(1'b0, 0, 1'b0);
    rst = 1'b0;
    expDuty = int'($urandom_range(1, 60));
    driveTo(expDuty, 2000);
    checkValue("t6Recover", 32'(pulseWidth), 32'(expDuty));

    // Random traffic against the model
    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 2) == 0, int'($urandom_range(0, 255)), $urandom_range(0, 39) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
